// File: rtl/fetch_queue_if.sv
// Fetch stage bus bundle: instruction-memory port, redirect input and downstream head port.
// Optional perf counter outputs exist only when FETCH_PERF_CNT_EN is defined.
interface fetch_queue_if #(
    parameter int INS_W = 16,
    parameter int PC_W  = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic [INS_W-1:0] imem_data;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic             out_valid;
    logic [INS_W-1:0] out_ins;
    logic [PC_W-1:0]  out_pc;
    logic             out_ready;
    logic [CW-1:0]    fifo_count;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0]      stall_cycles;
    logic [7:0]       flush_count;
`endif

    modport master (
        output imem_req, imem_addr,
        input  imem_data,
        input  redirect_valid, redirect_pc,
        output out_valid, out_ins, out_pc,
        input  out_ready,
        output fifo_count
`ifdef FETCH_PERF_CNT_EN
        , output stall_cycles, flush_count
`endif
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_data,
        output redirect_valid, redirect_pc,
        input  out_valid, out_ins, out_pc,
        output out_ready,
        input  fifo_count
`ifdef FETCH_PERF_CNT_EN
        , input stall_cycles, flush_count
`endif
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch: PC, synchronous imem reads, small {pc, ins} FIFO with redirect flush.
// Define FETCH_PERF_CNT_EN to add saturating stall_cycles / flush_count counters.
module fetch_queue #(
    parameter int          INS_W    = 16,
    parameter int          PC_W     = 8,
    parameter int          DEPTH    = 4,
    parameter int unsigned RESET_PC = 0
) (
    input logic            clk,
    input logic            rst,
    fetch_queue_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [PC_W-1:0] RESET_PC_C = RESET_PC[PC_W-1:0];
    localparam logic [CW:0]     DEPTH_C    = DEPTH[CW:0];

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  req_pc_q;
    logic             inflight_q;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [INS_W-1:0] ins_mem_q [DEPTH];
    logic [PC_W-1:0]  pc_mem_q  [DEPTH];

    logic             redirect;
    logic             req;
    logic             push;
    logic             pop;
    logic             not_empty;
    logic [CW:0]      occupancy;

    assign redirect  = bus.redirect_valid;
    assign not_empty = (count_q != '0);
    assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    // FETCH when there is room for one more response, IDLE otherwise or during a redirect
    assign req       = !rst && !redirect && (occupancy < DEPTH_C);
    // a response arriving in a redirect cycle belongs to the old stream and is dropped
    assign push      = inflight_q && !redirect;
    assign pop       = not_empty && bus.out_ready && !redirect;

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q + AW'(pop);
        wr_ptr_d = wr_ptr_q + AW'(push);
        count_d  = count_q + CW'(push) - CW'(pop);
        if (redirect) begin
            pc_d     = bus.redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (req) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC_C;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= req;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            if (req) begin
                req_pc_q <= pc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ins_mem_q[wr_ptr_q] <= bus.imem_data;
            pc_mem_q[wr_ptr_q]  <= req_pc_q;
        end
    end

    assign bus.imem_req   = req;
    assign bus.imem_addr  = req ? pc_q : '0;
    assign bus.out_valid  = not_empty;
    assign bus.out_ins    = not_empty ? ins_mem_q[rd_ptr_q] : '0;
    assign bus.out_pc     = not_empty ? pc_mem_q[rd_ptr_q] : '0;
    assign bus.fifo_count = count_q;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_q, stall_d;
    logic [7:0]  flush_q, flush_d;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!req && !redirect && (stall_q != '1)) begin
            stall_d = stall_q + 16'd1;
        end
        if (redirect && (flush_q != '1)) begin
            flush_d = flush_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign bus.stall_cycles = stall_q;
    assign bus.flush_count  = flush_q;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, back-pressure, redirect flush, PC wrap, async reset.
module tb_fetch_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   fails = 0;

    fetch_queue_if #(.INS_W(16), .PC_W(8), .DEPTH(4)) bus ();
    fetch_queue_if #(.INS_W(16), .PC_W(8), .DEPTH(4)) bus2 ();

    fetch_queue #(.INS_W(16), .PC_W(8), .DEPTH(4), .RESET_PC(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fetch_queue #(.INS_W(16), .PC_W(8), .DEPTH(4), .RESET_PC(8'hFE)) dut_fe (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    // synchronous instruction memory: data = 0x1000 + addr, one cycle after the request
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_data <= 16'h1000 + {8'h00, bus.imem_addr};
        if (bus2.imem_req) bus2.imem_data <= 16'h1000 + {8'h00, bus2.imem_addr};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // leaves rst released right at a falling edge (cycle 0 starts there)
    task automatic apply_reset(input logic ready);
        @(negedge clk);
        rst = 1'b1;
        bus.out_ready = ready;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 8'h00;
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus.imem_req !== 1'b0 || bus.imem_addr !== 8'h00) begin
            fails++;
            $display("FAIL reset_imem: req=%b addr=%h, want req=0 addr=00", bus.imem_req, bus.imem_addr);
        end
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.out_ins !== 16'h0000 || bus.out_pc !== 8'h00) begin
            fails++;
            $display("FAIL reset_out: valid=%b ins=%h pc=%h, want 0/0000/00", bus.out_valid, bus.out_ins, bus.out_pc);
        end
        tests_run++;
        if (bus.fifo_count !== 3'd0) begin
            fails++;
            $display("FAIL reset_count: got %0d want 0", bus.fifo_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        apply_reset(1'b1);
        #1;
        tests_run++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin
            fails++;
            $display("FAIL stream_first_req: req=%b addr=%h, want 1/00", bus.imem_req, bus.imem_addr);
        end
        @(negedge clk);
        tests_run++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h01 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL stream_cycle1: req=%b addr=%h valid=%b, want 1/01/0", bus.imem_req, bus.imem_addr, bus.out_valid);
        end
        @(negedge clk);
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h00 || bus.out_ins !== 16'h1000 || bus.fifo_count !== 3'd1) begin
            fails++;
            $display("FAIL stream_first_out: valid=%b pc=%h ins=%h cnt=%0d, want 1/00/1000/1",
                     bus.out_valid, bus.out_pc, bus.out_ins, bus.fifo_count);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== k[7:0] || bus.out_ins !== 16'h1000 + k[15:0]) begin
                fails++;
                $display("FAIL stream_seq[%0d]: valid=%b pc=%h ins=%h, want 1/%h/%h",
                         k, bus.out_valid, bus.out_pc, bus.out_ins, k[7:0], 16'h1000 + k[15:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        int nreq = 0;
        apply_reset(1'b0);
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bus.imem_req) nreq++;
            @(negedge clk);
        end
        tests_run++;
        if (nreq != 4) begin
            fails++;
            $display("FAIL bp_requests: got %0d want 4", nreq);
        end
        tests_run++;
        if (bus.fifo_count !== 3'd4 || bus.imem_req !== 1'b0) begin
            fails++;
            $display("FAIL bp_full: cnt=%0d req=%b, want 4/0", bus.fifo_count, bus.imem_req);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== i[7:0] || bus.out_ins !== 16'h1000 + i[15:0]) begin
                fails++;
                $display("FAIL bp_drain[%0d]: valid=%b pc=%h ins=%h, want 1/%h/%h",
                         i, bus.out_valid, bus.out_pc, bus.out_ins, i[7:0], 16'h1000 + i[15:0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect();
        apply_reset(1'b0);
        repeat (4) @(negedge clk);
        #1;
        tests_run++;
        if (bus.fifo_count !== 3'd3 || bus.imem_req !== 1'b0) begin
            fails++;
            $display("FAIL redir_setup: cnt=%0d req=%b, want 3/0", bus.fifo_count, bus.imem_req);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 8'h40;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        tests_run++;
        if (bus.fifo_count !== 3'd0 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL redir_flush: cnt=%0d valid=%b, want 0/0", bus.fifo_count, bus.out_valid);
        end
        tests_run++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h40) begin
            fails++;
            $display("FAIL redir_req: req=%b addr=%h, want 1/40", bus.imem_req, bus.imem_addr);
        end
        @(negedge clk);
        tests_run++;
        if (bus.fifo_count !== 3'd0 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL redir_kill: cnt=%0d valid=%b pc=%h, want 0/0", bus.fifo_count, bus.out_valid, bus.out_pc);
        end
        @(negedge clk);
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h40 || bus.out_ins !== 16'h1040) begin
            fails++;
            $display("FAIL redir_first: valid=%b pc=%h ins=%h, want 1/40/1040", bus.out_valid, bus.out_pc, bus.out_ins);
        end
        @(negedge clk);
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h41) begin
            fails++;
            $display("FAIL redir_second: valid=%b pc=%h, want 1/41", bus.out_valid, bus.out_pc);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset(1'b1);
        repeat (3) @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 8'h80;
        #1;
        tests_run++;
        if (bus.imem_req !== 1'b0) begin
            fails++;
            $display("FAIL b2b_block1: req=%b want 0", bus.imem_req);
        end
        @(negedge clk);
        bus.redirect_pc = 8'h90;
        #1;
        tests_run++;
        if (bus.imem_req !== 1'b0 || bus.fifo_count !== 3'd0) begin
            fails++;
            $display("FAIL b2b_block2: req=%b cnt=%0d, want 0/0", bus.imem_req, bus.fifo_count);
        end
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        tests_run++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h90) begin
            fails++;
            $display("FAIL b2b_req: req=%b addr=%h, want 1/90", bus.imem_req, bus.imem_addr);
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h90 || bus.out_ins !== 16'h1090) begin
            fails++;
            $display("FAIL b2b_out: valid=%b pc=%h ins=%h, want 1/90/1090", bus.out_valid, bus.out_pc, bus.out_ins);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_addr [4];
        exp_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        apply_reset(1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++;
            if (bus2.imem_req !== 1'b1 || bus2.imem_addr !== exp_addr[i]) begin
                fails++;
                $display("FAIL wrap_addr[%0d]: req=%b addr=%h, want 1/%h", i, bus2.imem_req, bus2.imem_addr, exp_addr[i]);
            end
            @(negedge clk);
        end
        #1;
        tests_run++;
        if (bus2.out_valid !== 1'b1 || bus2.out_pc !== 8'h00 || bus2.out_ins !== 16'h1000) begin
            fails++;
            $display("FAIL wrap_out: valid=%b pc=%h ins=%h, want 1/00/1000", bus2.out_valid, bus2.out_pc, bus2.out_ins);
        end
    endtask

    task automatic test_async_reset();
        apply_reset(1'b0);
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.fifo_count !== 3'd0 || bus.imem_req !== 1'b0 || bus.out_pc !== 8'h00) begin
            fails++;
            $display("FAIL arst_clear: valid=%b cnt=%0d req=%b pc=%h, want 0/0/0/00",
                     bus.out_valid, bus.fifo_count, bus.imem_req, bus.out_pc);
        end
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h01 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL arst_restart: req=%b addr=%h valid=%b, want 1/01/0", bus.imem_req, bus.imem_addr, bus.out_valid);
        end
        @(negedge clk);
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h00 || bus.out_ins !== 16'h1000) begin
            fails++;
            $display("FAIL arst_first: valid=%b pc=%h ins=%h, want 1/00/1000", bus.out_valid, bus.out_pc, bus.out_ins);
        end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf_counters();
        apply_reset(1'b0);
        repeat (20) @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 8'h10;
        repeat (2) @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        tests_run++;
        if (bus.stall_cycles !== 16'd16 || bus.flush_count !== 8'd2) begin
            fails++;
            $display("FAIL perf_counts: stall=%0d flush=%0d, want 16/2", bus.stall_cycles, bus.flush_count);
        end
    endtask
`endif

    initial begin
        bus.out_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 8'h00;
        bus2.out_ready = 1'b1;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc = 8'h00;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_async_reset();
`ifdef FETCH_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
